// File: rtl/grid_locator.sv
// grid_locator: maps raw hdata/vdata to registered board cell row/col, in-cell offsets and grid-line flag
//   clk, reset      pixel clock, synchronous active-high reset
//   hdata, vdata    raw pixel coordinates from the timing generator
//   de_in / de_out  data enable in, and delayed one clk to match the outputs
//   col, row        cell index of the pixel sampled last cycle (N_CELLS marks the closing border)
//   x_off, y_off    offset of that pixel inside its cell
//   in_grid         pixel lies on the board span, closing border included
//   cell_valid      in_grid, inside a real cell, and de_out set
//   grid_line       in_grid and on a cell border line
module grid_locator #(
    parameter int WIDTH = 12,
    parameter int GRID_X0 = 50,
    parameter int GRID_Y0 = 50,
    parameter int CELL = 50,
    parameter int N_CELLS = 10,
    localparam int OW = $clog2(CELL),
    localparam int CW = $clog2(N_CELLS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] hdata,
    input  logic [WIDTH-1:0] vdata,
    input  logic             de_in,
    output logic             de_out,
    output logic [CW-1:0]    col,
    output logic [CW-1:0]    row,
    output logic [OW-1:0]    x_off,
    output logic [OW-1:0]    y_off,
    output logic             in_grid,
    output logic             cell_valid,
    output logic             grid_line
);
    logic in_x, in_y, nx_in_x, nx_in_y, nx_grid;
    logic x_hit, x_end, x_wrap, x_clr, y_hit, y_end, y_wrap, y_clr, line_start;
    logic [CW-1:0] nx_col, nx_row;
    logic [OW-1:0] nx_x_off, nx_y_off;

    // Cell position is tracked with counters that restart on the border hit,
    // so no divide or modulo is ever applied to the raw coordinates.
    always_comb begin
        x_hit = hdata == WIDTH'(GRID_X0);
        x_end = col == CW'(N_CELLS);
        x_wrap = x_off == OW'(CELL - 1);
        x_clr = x_hit || !in_x || x_end;
        nx_in_x = x_hit || (in_x && !x_end);
        nx_col = x_clr ? '0 : x_wrap ? col + CW'(1) : col;
        nx_x_off = (x_clr || x_wrap) ? '0 : x_off + OW'(1);
        // Y advances once per line, on the cycle hdata wraps to 0.
        line_start = hdata == '0;
        y_hit = vdata == WIDTH'(GRID_Y0);
        y_end = row == CW'(N_CELLS);
        y_wrap = y_off == OW'(CELL - 1);
        y_clr = y_hit || !in_y || y_end;
        nx_in_y = line_start ? (y_hit || (in_y && !y_end)) : in_y;
        nx_row = !line_start ? row : y_clr ? '0 : y_wrap ? row + CW'(1) : row;
        nx_y_off = !line_start ? y_off : (y_clr || y_wrap) ? '0 : y_off + OW'(1);
        nx_grid = nx_in_x && nx_in_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_x <= 1'b0;
            in_y <= 1'b0;
            col <= '0;
            row <= '0;
            x_off <= '0;
            y_off <= '0;
            de_out <= 1'b0;
            in_grid <= 1'b0;
            cell_valid <= 1'b0;
            grid_line <= 1'b0;
        end else begin
            in_x <= nx_in_x;
            in_y <= nx_in_y;
            col <= nx_col;
            row <= nx_row;
            x_off <= nx_x_off;
            y_off <= nx_y_off;
            de_out <= de_in;
            in_grid <= nx_grid;
            cell_valid <= nx_grid && nx_col < CW'(N_CELLS) && nx_row < CW'(N_CELLS) && de_in;
            grid_line <= nx_grid && (nx_x_off == '0 || nx_y_off == '0);
        end
    end
endmodule
